// File: rtl/sdram_responder.sv
// Behavioural SDR SDRAM target: command decode, bank tracking, CL-delayed reads, byte-masked writes.
// Define SDRAM_RESP_CHECK_EN to enable protocol-error reporting on err/err_code.
module sdram_responder #(
  parameter int unsigned MEM_AW = 12,
  parameter int unsigned RCD    = 3
) (
  input  logic        clk,
  input  logic        init,
  input  logic        sd_cke,
  input  logic        sd_ncs,
  input  logic        sd_nras,
  input  logic        sd_ncas,
  input  logic        sd_nwe,
  input  logic [1:0]  sd_ba,
  input  logic [12:0] sd_a,
  input  logic        sd_dqml,
  input  logic        sd_dqmh,
  input  logic [15:0] sd_dq_in,
  output logic [15:0] sd_dq_out,
  output logic        sd_dq_oe,
  output logic        mode_loaded,
  output logic [15:0] refresh_cnt,
  output logic        err,
  output logic [2:0]  err_code
);

  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_RD  = 3'b101;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_LMR = 3'b000;

  logic [15:0] mem [2**MEM_AW];

  logic [3:0]        open_q, open_d;
  logic [3:0][12:0]  row_q, row_d;
  logic [3:0][2:0]   cnt_q, cnt_d;
  logic [2:0]        cl_q, cl_d;
  logic              mode_q, mode_d;
  logic [15:0]       ref_q, ref_d;
  logic [2:0]        pvld_q, pvld_d;
  logic [2:0][15:0]  pdat_q, pdat_d;
  logic [15:0]       dq_out_q, dq_out_d;
  logic              dq_oe_q, dq_oe_d;

  logic [2:0]  cmd;
  logic        cmd_vld, is_act, is_rd, is_wr, is_pre, is_ref, is_lmr, rw;
  logic        any_open, cur_open, act_ok, rw_ok, cl_ok;
  logic [23:0] addr_full;
  logic [MEM_AW-1:0] mem_idx;
  logic [15:0] mem_rd;

  assign cmd      = {sd_nras, sd_ncas, sd_nwe};
  assign cmd_vld  = sd_cke & ~sd_ncs;
  assign is_act   = cmd_vld && (cmd == CMD_ACT);
  assign is_rd    = cmd_vld && (cmd == CMD_RD);
  assign is_wr    = cmd_vld && (cmd == CMD_WR);
  assign is_pre   = cmd_vld && (cmd == CMD_PRE);
  assign is_ref   = cmd_vld && (cmd == CMD_REF);
  assign is_lmr   = cmd_vld && (cmd == CMD_LMR);
  assign rw       = is_rd | is_wr;
  assign any_open = |open_q;
  assign cur_open = open_q[sd_ba];
  assign act_ok   = is_act & mode_q & ~cur_open;
  assign rw_ok    = rw & mode_q & cur_open;
  assign cl_ok    = (sd_a[6:4] == 3'd2) || (sd_a[6:4] == 3'd3);

  assign addr_full = {sd_ba, row_q[sd_ba], sd_a[8:0]};
  assign mem_idx   = addr_full[MEM_AW-1:0];
  assign mem_rd    = mem[mem_idx];

  always_comb begin
    open_d = open_q;
    row_d  = row_q;
    cnt_d  = cnt_q;
    for (int unsigned b = 0; b < 4; b++) begin
      cnt_d[b] = (cnt_q[b] == 3'd7) ? 3'd7 : cnt_q[b] + 3'd1;
      if ((is_pre && (sd_a[10] || sd_ba == 2'(b))) ||
          (rw_ok && sd_a[10] && sd_ba == 2'(b)))
        open_d[b] = 1'b0;
      // Count starts at 1 so a command k edges after ACTIVE sees k.
      if (act_ok && sd_ba == 2'(b)) begin
        open_d[b] = 1'b1;
        row_d[b]  = sd_a;
        cnt_d[b]  = 3'd1;
      end
    end

    mode_d = mode_q | is_lmr;
    cl_d   = (is_lmr && cl_ok) ? sd_a[6:4] : cl_q;
    ref_d  = (is_ref && mode_q && !any_open && ref_q != 16'hFFFF) ? ref_q + 16'd1 : ref_q;

    // Stage 0 feeds the output register, so a read enters at stage CL-2.
    pvld_d = {1'b0, pvld_q[2:1]};
    pdat_d = {16'd0, pdat_q[2], pdat_q[1]};
    if (is_rd && rw_ok) begin
      if (cl_q == 3'd3) begin
        pvld_d[1] = 1'b1;
        pdat_d[1] = mem_rd;
      end else begin
        pvld_d[0] = 1'b1;
        pdat_d[0] = mem_rd;
      end
    end
    dq_oe_d  = pvld_q[0];
    dq_out_d = pvld_q[0] ? pdat_q[0] : '0;
  end

  always_ff @(posedge clk) begin
    if (init) begin
      open_q   <= '0;
      row_q    <= '0;
      cnt_q    <= '0;
      cl_q     <= 3'd2;
      mode_q   <= 1'b0;
      ref_q    <= '0;
      pvld_q   <= '0;
      pdat_q   <= '0;
      dq_out_q <= '0;
      dq_oe_q  <= 1'b0;
    end else begin
      open_q   <= open_d;
      row_q    <= row_d;
      cnt_q    <= cnt_d;
      cl_q     <= cl_d;
      mode_q   <= mode_d;
      ref_q    <= ref_d;
      pvld_q   <= pvld_d;
      pdat_q   <= pdat_d;
      dq_out_q <= dq_out_d;
      dq_oe_q  <= dq_oe_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!init && is_wr && rw_ok) begin
      if (!sd_dqml) mem[mem_idx][7:0]  <= sd_dq_in[7:0];
      if (!sd_dqmh) mem[mem_idx][15:8] <= sd_dq_in[15:8];
    end
  end

  assign sd_dq_out   = dq_out_q;
  assign sd_dq_oe    = dq_oe_q;
  assign mode_loaded = mode_q;
  assign refresh_cnt = ref_q;

`ifdef SDRAM_RESP_CHECK_EN
  localparam logic [3:0] RCD_C = (RCD > 7) ? 4'd8 : 4'(RCD);

  logic       err_q, err_d;
  logic [2:0] code_q, code_d, code_new;

  always_comb begin
    code_new = 3'd0;
    if (is_lmr && !cl_ok)                           code_new = 3'd6;
    if (((is_ref && mode_q) || is_lmr) && any_open) code_new = 3'd5;
    if (rw_ok && ({1'b0, cnt_q[sd_ba]} < RCD_C))    code_new = 3'd4;
    if (rw && mode_q && !cur_open)                  code_new = 3'd3;
    if (is_act && mode_q && cur_open)               code_new = 3'd2;
    if ((is_act || rw || is_ref) && !mode_q)        code_new = 3'd1;
    err_d  = err_q;
    code_d = code_q;
    if (!err_q && code_new != 3'd0) begin
      err_d  = 1'b1;
      code_d = code_new;
    end
  end

  always_ff @(posedge clk) begin
    if (init) begin
      err_q  <= 1'b0;
      code_q <= '0;
    end else begin
      err_q  <= err_d;
      code_q <= code_d;
    end
  end

  assign err      = err_q;
  assign err_code = code_q;
`else
  assign err      = 1'b0;
  assign err_code = '0;
`endif

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder; error expectations follow SDRAM_RESP_CHECK_EN.
module tb_sdram_responder;

`ifdef SDRAM_RESP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_LMR = 3'b000;

  logic        clk = 1'b0;
  logic        init, sd_cke, sd_ncs, sd_nras, sd_ncas, sd_nwe;
  logic [1:0]  sd_ba;
  logic [12:0] sd_a;
  logic        sd_dqml, sd_dqmh;
  logic [15:0] sd_dq_in, sd_dq_out, refresh_cnt;
  logic        sd_dq_oe, mode_loaded, err;
  logic [2:0]  err_code;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sdram_responder #(.MEM_AW(12), .RCD(3)) dut (
    .clk(clk), .init(init), .sd_cke(sd_cke), .sd_ncs(sd_ncs),
    .sd_nras(sd_nras), .sd_ncas(sd_ncas), .sd_nwe(sd_nwe),
    .sd_ba(sd_ba), .sd_a(sd_a), .sd_dqml(sd_dqml), .sd_dqmh(sd_dqmh),
    .sd_dq_in(sd_dq_in), .sd_dq_out(sd_dq_out), .sd_dq_oe(sd_dq_oe),
    .mode_loaded(mode_loaded), .refresh_cnt(refresh_cnt),
    .err(err), .err_code(err_code)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] a,
                       input logic ml, input logic mh, input logic [15:0] d);
    sd_ncs = 1'b0;
    {sd_nras, sd_ncas, sd_nwe} = c;
    sd_ba = ba; sd_a = a; sd_dqml = ml; sd_dqmh = mh; sd_dq_in = d;
    tick(1);
    sd_ncs = 1'b1;
    {sd_nras, sd_ncas, sd_nwe} = 3'b111;
  endtask

  task automatic do_reset();
    init = 1'b1;
    tick(2);
    init = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    init = 1'b1; sd_cke = 1'b1; sd_ncs = 1'b1;
    {sd_nras, sd_ncas, sd_nwe} = 3'b111;
    sd_ba = '0; sd_a = '0; sd_dqml = 1'b0; sd_dqmh = 1'b0; sd_dq_in = '0;
    do_reset();
    check_eq("rst_mode", mode_loaded, 0);
    check_eq("rst_ref",  refresh_cnt, 0);
    check_eq("rst_oe",   sd_dq_oe, 0);
    check_eq("rst_dq",   sd_dq_out, 0);
    check_eq("rst_err",  err, 0);
    check_eq("rst_code", err_code, 0);

    // CL=2, masked write with auto-precharge, then read back
    issue(C_LMR, 2'd0, 13'h0220, 0, 0, 16'h0);
    check_eq("lmr_mode", mode_loaded, 1);
    check_eq("lmr_err",  err, 0);
    issue(C_ACT, 2'd1, 13'd5, 0, 0, 16'h0);
    tick(2);
    issue(C_WR, 2'd1, 13'h409, 0, 1, 16'hA55A);
    issue(C_ACT, 2'd1, 13'd5, 0, 0, 16'h0);
    tick(2);
    issue(C_RD, 2'd1, 13'd9, 0, 0, 16'h0);
    check_eq("cl2_oe_n", sd_dq_oe, 0);
    tick(1);
    check_eq("cl2_oe_n1", sd_dq_oe, 1);
    check_eq("cl2_lo",    sd_dq_out[7:0], 8'h5A);
    tick(1);
    check_eq("cl2_oe_n2", sd_dq_oe, 0);

    issue(C_WR, 2'd1, 13'd10, 0, 0, 16'h1234);
    issue(C_WR, 2'd1, 13'd10, 1, 0, 16'hABCD);
    issue(C_RD, 2'd1, 13'd10, 1, 1, 16'h0);
    tick(1);
    check_eq("mask_oe", sd_dq_oe, 1);
    check_eq("mask_dq", sd_dq_out, 16'hAB34);
    check_eq("a_err",   err, 0);

    // CL=3, back-to-back reads
    issue(C_PRE, 2'd0, 13'h400, 0, 0, 16'h0);
    issue(C_LMR, 2'd0, 13'h0030, 0, 0, 16'h0);
    issue(C_ACT, 2'd1, 13'd5, 0, 0, 16'h0);
    tick(2);
    issue(C_RD, 2'd1, 13'd9, 0, 0, 16'h0);
    issue(C_RD, 2'd1, 13'd10, 0, 0, 16'h0);
    check_eq("cl3_oe_n1", sd_dq_oe, 0);
    tick(1);
    check_eq("cl3_oe_n2", sd_dq_oe, 1);
    check_eq("cl3_beat0", sd_dq_out[7:0], 8'h5A);
    tick(1);
    check_eq("cl3_oe_n3", sd_dq_oe, 1);
    check_eq("cl3_beat1", sd_dq_out, 16'hAB34);
    tick(1);
    check_eq("cl3_oe_n4", sd_dq_oe, 0);
    check_eq("b_err",     err, 0);

    // refresh counting and refresh-with-open-bank error
    issue(C_PRE, 2'd0, 13'h400, 0, 0, 16'h0);
    for (int i = 0; i < 3; i++) issue(C_REF, 2'd0, 13'd0, 0, 0, 16'h0);
    check_eq("ref_cnt3", refresh_cnt, 3);
    check_eq("ref_err0", err, 0);
    issue(C_ACT, 2'd0, 13'd0, 0, 0, 16'h0);
    issue(C_REF, 2'd0, 13'd0, 0, 0, 16'h0);
    check_eq("ref_open_err",  err, 32'(CHK));
    check_eq("ref_open_code", err_code, CHK ? 5 : 0);
    check_eq("ref_open_cnt",  refresh_cnt, 3);
    issue(C_ACT, 2'd0, 13'd0, 0, 0, 16'h0);
    check_eq("sticky_code", err_code, CHK ? 5 : 0);

    // init one cycle after a CL=3 read discards it
    tick(3);
    issue(C_RD, 2'd0, 13'd0, 0, 0, 16'h0);
    check_eq("flush_oe_n", sd_dq_oe, 0);
    init = 1'b1;
    tick(1);
    init = 1'b0;
    check_eq("reinit_mode", mode_loaded, 0);
    check_eq("reinit_ref",  refresh_cnt, 0);
    check_eq("reinit_code", err_code, 0);
    for (int i = 0; i < 4; i++) begin
      check_eq("flush_oe", sd_dq_oe, 0);
      tick(1);
    end

    // RCD violation still returns data; store survived init
    issue(C_LMR, 2'd0, 13'h0220, 0, 0, 16'h0);
    issue(C_ACT, 2'd1, 13'd5, 0, 0, 16'h0);
    tick(1);
    issue(C_RD, 2'd1, 13'd9, 0, 0, 16'h0);
    check_eq("rcd_err",  err, 32'(CHK));
    check_eq("rcd_code", err_code, CHK ? 4 : 0);
    tick(1);
    check_eq("rcd_oe",   sd_dq_oe, 1);
    check_eq("rcd_data", sd_dq_out[7:0], 8'h5A);

    // commands before LOAD_MODE are ignored; bad CL keeps CL=2
    do_reset();
    issue(C_ACT, 2'd1, 13'd5, 0, 0, 16'h0);
    check_eq("nomode_code", err_code, CHK ? 1 : 0);
    issue(C_LMR, 2'd0, 13'h0020, 0, 0, 16'h0);
    issue(C_LMR, 2'd0, 13'h0050, 0, 0, 16'h0);
    check_eq("badcl_mode", mode_loaded, 1);
    issue(C_RD, 2'd1, 13'd9, 0, 0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check_eq("idle_rd_oe", sd_dq_oe, 0);
    end
    issue(C_ACT, 2'd1, 13'd5, 0, 0, 16'h0);
    tick(2);
    issue(C_RD, 2'd1, 13'd9, 0, 0, 16'h0);
    tick(1);
    check_eq("keepcl_oe", sd_dq_oe, 1);
    check_eq("keepcl_lo", sd_dq_out[7:0], 8'h5A);
    check_eq("first_code", err_code, CHK ? 1 : 0);

    // CKE low ignores commands
    issue(C_PRE, 2'd0, 13'h400, 0, 0, 16'h0);
    sd_cke = 1'b0;
    issue(C_REF, 2'd0, 13'd0, 0, 0, 16'h0);
    check_eq("cke0_ref", refresh_cnt, 0);
    sd_cke = 1'b1;
    issue(C_REF, 2'd0, 13'd0, 0, 0, 16'h0);
    check_eq("cke1_ref", refresh_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
